// File: rtl/configure_machine_pkg.sv
// Shared types and helpers for the parallel light-toggle subset search.
package configure_machine_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SEARCH,
        ST_DRAIN,
        ST_FINAL,
        ST_DONE
    } state_t;

    // Width of a count that must hold 0..n (never narrower than one bit).
    function automatic int lights_w(input int n);
        return (n < 1) ? 1 : $clog2(n + 1);
    endfunction

    function automatic int buttons_w(input int n);
        return (n < 1) ? 1 : $clog2(n + 1);
    endfunction

    function automatic int popcount(input logic [31:0] v);
        int c;
        c = 0;
        for (int i = 0; i < 32; i++) c += int'(v[i]);
        return c;
    endfunction

endpackage

// File: rtl/configure_machine_par_lane.sv
// One candidate evaluator: XOR of the buttons selected by mask versus target.
module cm_lane
    import configure_machine_pkg::*;
#(
    parameter int MAX_NUM_LIGHTS  = 16,
    parameter int MAX_NUM_BUTTONS = 13
) (
    input  logic [MAX_NUM_BUTTONS-1:0]            mask,
    input  logic [MAX_NUM_LIGHTS-1:0]             buttons [MAX_NUM_BUTTONS],
    input  logic [MAX_NUM_LIGHTS-1:0]             target,
    input  logic [buttons_w(MAX_NUM_BUTTONS)-1:0] num_buttons,
    output logic                                  hit,
    output logic [buttons_w(MAX_NUM_BUTTONS)-1:0] pop
);
    localparam int BW = buttons_w(MAX_NUM_BUTTONS);

    logic [MAX_NUM_LIGHTS-1:0] acc;

    // Accumulate the toggle pattern of every selected, active button.
    always_comb begin
        acc = '0;
        for (int b = 0; b < MAX_NUM_BUTTONS; b++) begin
            if (mask[b] && (b < int'(num_buttons))) acc = acc ^ buttons[b];
        end
        hit = (acc == target);
        pop = BW'(popcount(32'(mask)));
    end

endmodule

// File: rtl/configure_machine_par.sv
// Parallel minimum-press search: LANES subsets per cycle, streams every hit,
// then a tlast beat carrying the best (fewest presses, lowest mask) subset.
module configure_machine_par
    import configure_machine_pkg::*;
#(
    parameter int MAX_NUM_LIGHTS  = 16,
    parameter int MAX_NUM_BUTTONS = 13,
    parameter int LANES           = 4
) (
    input  logic                                  clk,
    input  logic                                  rst_n,
    input  logic [lights_w(MAX_NUM_LIGHTS)-1:0]   num_lights,
    input  logic [buttons_w(MAX_NUM_BUTTONS)-1:0] num_buttons,
    input  logic                                  start,
    input  logic [MAX_NUM_LIGHTS-1:0]             buttons [MAX_NUM_BUTTONS],
    input  logic [MAX_NUM_LIGHTS-1:0]             target_lights_arrangement,
    output logic                                  ready,
    output logic                                  done,
    output logic                                  found,
    output logic [buttons_w(MAX_NUM_BUTTONS)-1:0] min_button_presses,
    output logic [MAX_NUM_BUTTONS-1:0]            buttons_to_press,
    output logic [MAX_NUM_BUTTONS-1:0]            solution_stream_tdata,
    output logic                                  solution_stream_tvalid,
    input  logic                                  solution_stream_tready,
    output logic                                  solution_stream_tlast
);
    localparam int ML = MAX_NUM_LIGHTS;
    localparam int MB = MAX_NUM_BUTTONS;
    localparam int BW = buttons_w(MB);
    // Two spare bits so base + LANES never wraps even at 2^MB masks.
    localparam int CW = MB + 2;
    localparam int IW = (LANES > 1) ? $clog2(LANES) : 1;

    state_t state, nxt;

    logic [ML-1:0]    lat_buttons [MB];
    logic [ML-1:0]    lat_target;
    logic [BW-1:0]    lat_nb;
    logic [CW-1:0]    base;
    logic [CW-1:0]    total;
    logic             last_chunk;
    logic [LANES-1:0] pend;
    logic [LANES-1:0] pend_clr;
    logic [IW-1:0]    low;
    logic [ML-1:0]    light_mask;

    logic             best_found;
    logic [MB-1:0]    best_mask;
    logic [BW-1:0]    best_pop;
    logic             c_found;
    logic [MB-1:0]    c_mask;
    logic [BW-1:0]    c_pop;

    logic [LANES-1:0]         lane_hit;
    logic [LANES-1:0]         lane_en;
    logic [LANES-1:0]         hits;
    logic [LANES-1:0][CW-1:0] lane_sum;
    logic [LANES-1:0][BW-1:0] lane_pop;

    // Lights at or above num_lights never participate.
    always_comb begin
        if (int'(num_lights) >= ML) light_mask = '1;
        else                        light_mask = (ML'(1) << num_lights) - ML'(1);
    end

    assign total      = CW'(1) << lat_nb;
    assign last_chunk = (base + CW'(LANES)) >= total;

    for (genvar l = 0; l < LANES; l++) begin : g_lane
        assign lane_sum[l] = base + CW'(l);
        assign lane_en[l]  = lane_sum[l] < total;
        cm_lane #(
            .MAX_NUM_LIGHTS (ML),
            .MAX_NUM_BUTTONS(MB)
        ) u_lane (
            .mask       (MB'(lane_sum[l])),
            .buttons    (lat_buttons),
            .target     (lat_target),
            .num_buttons(lat_nb),
            .hit        (lane_hit[l]),
            .pop        (lane_pop[l])
        );
    end

    assign hits = lane_hit & lane_en;

    // Fold this chunk's hits into the running best, lowest lane first so
    // equal popcounts keep the numerically smaller mask.
    always_comb begin
        c_found = best_found;
        c_mask  = best_mask;
        c_pop   = best_pop;
        for (int l = 0; l < LANES; l++) begin
            if (hits[l] && (!c_found || lane_pop[l] < c_pop)) begin
                c_found = 1'b1;
                c_mask  = MB'(lane_sum[l]);
                c_pop   = lane_pop[l];
            end
        end
    end

    // Lowest pending lane is the next hit to emit.
    always_comb begin
        low = '0;
        for (int l = LANES - 1; l >= 0; l--) begin
            if (pend[l]) low = IW'(l);
        end
        pend_clr = pend & ~(LANES'(1) << low);
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= ST_IDLE;
        else        state <= nxt;
    end

    // Next state and stream/handshake outputs.
    always_comb begin
        nxt                    = state;
        ready                  = 1'b0;
        done                   = 1'b0;
        solution_stream_tvalid = 1'b0;
        solution_stream_tlast  = 1'b0;
        solution_stream_tdata  = '0;
        case (state)
            ST_IDLE: begin
                ready = 1'b1;
                if (start) nxt = ST_SEARCH;
            end
            ST_SEARCH: begin
                if (hits != '0)      nxt = ST_DRAIN;
                else if (last_chunk) nxt = ST_FINAL;
            end
            ST_DRAIN: begin
                solution_stream_tvalid = 1'b1;
                solution_stream_tdata  = MB'(base + CW'(low));
                if (solution_stream_tready && pend_clr == '0)
                    nxt = last_chunk ? ST_FINAL : ST_SEARCH;
            end
            ST_FINAL: begin
                solution_stream_tvalid = 1'b1;
                solution_stream_tlast  = 1'b1;
                solution_stream_tdata  = best_mask;
                if (solution_stream_tready) nxt = ST_DONE;
            end
            ST_DONE: begin
                done = 1'b1;
                nxt  = ST_IDLE;
            end
            default: nxt = ST_IDLE;
        endcase
    end

    // Operand latch, chunk walk, pending bitmap, best tracking and results.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int b = 0; b < MB; b++) lat_buttons[b] <= '0;
            lat_target         <= '0;
            lat_nb             <= '0;
            base               <= '0;
            pend               <= '0;
            best_found         <= 1'b0;
            best_mask          <= '0;
            best_pop           <= '0;
            found              <= 1'b0;
            min_button_presses <= '0;
            buttons_to_press   <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        for (int b = 0; b < MB; b++)
                            lat_buttons[b] <= (b < int'(num_buttons)) ? (buttons[b] & light_mask) : '0;
                        lat_target <= target_lights_arrangement & light_mask;
                        lat_nb     <= (int'(num_buttons) > MB) ? BW'(MB) : num_buttons;
                        base       <= '0;
                        pend       <= '0;
                        best_found <= 1'b0;
                        best_mask  <= '0;
                        best_pop   <= '0;
                    end
                end
                ST_SEARCH: begin
                    pend       <= hits;
                    best_found <= c_found;
                    best_mask  <= c_mask;
                    best_pop   <= c_pop;
                    if (hits == '0 && !last_chunk) base <= base + CW'(LANES);
                end
                ST_DRAIN: begin
                    if (solution_stream_tready) begin
                        pend <= pend_clr;
                        if (pend_clr == '0 && !last_chunk) base <= base + CW'(LANES);
                    end
                end
                ST_FINAL: begin
                    if (solution_stream_tready) begin
                        found              <= best_found;
                        min_button_presses <= best_pop;
                        buttons_to_press   <= best_mask;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
